decode_issue_queue: RTL
=======================

# decode_issue_queue

Small in-order FIFO between the decode stage and the issue stage. It holds decoded `scoreboard_entry_t` instructions with their control-flow flag, so decode does not stall on single-cycle issue back-pressure. It also enforces one-unresolved-control-flow gating: after a control-flow instruction issues, nothing further issues until execute resolves it. Flush and the fence.t micro-architectural clear both empty the queue.

## Interface
- `DEPTH`, default 4: number of entries; any integer ≥ 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: occupancy counter width; derived, not overridden.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; one clock; reset is asynchronous and active-high.
- `flush_i` in 1: discard all entries and pending-branch state.
- `clr_uarch_i` in 1: fence.t clear; same effect as `flush_i`.
- `decoded_instr_i` in `scoreboard_entry_t`: entry from decode.
- `decoded_instr_valid_i` in 1: decode presents an entry.
- `is_ctrl_flow_i` in 1: the entry is a branch/jump.
- `decoded_instr_ack_o` out 1: entry consumed this cycle.
- `issue_instr_o` out `scoreboard_entry_t`: head entry to issue.
- `issue_instr_valid_o` out 1: head entry is issuable.
- `is_ctrl_flow_o` out 1: head entry is control flow.
- `issue_ack_i` in 1: issue stage consumes the head this cycle.
- `resolve_branch_i` in 1: execute resolved the outstanding control-flow instruction.
- `branch_pending_o` out 1: an issued control-flow instruction is unresolved.
- `count_o` out `CNT_W`: current occupancy.
- `full_o` out 1: `count_o == DEPTH`.

## Operation
- Storage: circular buffer of `DEPTH` entries, each holding {entry, ctrl_flow}.
  - Read and write pointers wrap from `DEPTH-1` to 0; no power-of-2 requirement.
  - Occupancy is tracked in a separate counter.
- Push: `decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i & ~clr_uarch_i & ~rst_i`.
  - On ack, write at the write pointer and advance it.
  - No combinational path from `issue_ack_i` to `decoded_instr_ack_o`: a full queue refuses a push even when a pop occurs in the same cycle.
- Pop: `issue_instr_valid_o = (count_o != 0) & ~branch_pending_q`.
  - Pop happens when `issue_instr_valid_o & issue_ack_i`; the read pointer advances.
  - `issue_instr_o` and `is_ctrl_flow_o` always show the head slot, even when valid is low.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Branch gating FSM with states IDLE and PENDING:
  - IDLE→PENDING on a pop with head ctrl_flow = 1.
  - PENDING→IDLE on `resolve_branch_i`.
  - `resolve_branch_i` in IDLE is ignored.
  - If `resolve_branch_i` and a ctrl-flow pop coincide in IDLE, the next state is PENDING (resolve refers to an older instruction).
  - `branch_pending_o` = (state == PENDING).
- Flush/clear (`flush_i | clr_uarch_i`):
  - Next cycle: pointers 0, count 0, state IDLE.
  - Any push that cycle is refused; any pop that cycle is ignored for state purposes.
  - Flush takes priority over push, pop and resolve.
- Entry storage needs no reset. Pointers, count and FSM are reset asynchronously.

## Timing
- Reset values:
  - `issue_instr_valid_o` = 0, `decoded_instr_ack_o` = 0, `count_o` = 0, `full_o` = 0, `branch_pending_o` = 0.
  - `is_ctrl_flow_o` = 0 (slot 0 is cleared on reset).
  - `issue_instr_o` = slot 0 contents (cleared to '0 on reset).
- Latency: an entry pushed in cycle N is visible with `issue_instr_valid_o` = 1 in cycle N+1. There is no bypass.
- Throughput: one push and one pop per cycle in steady state.
- Reset deassertion: first push can be accepted in the cycle after `rst_i` falls.
- Reset mid-operation: all entries are lost immediately (asynchronous); outputs follow the reset values within the same cycle.
- After a ctrl-flow pop in cycle N, `issue_instr_valid_o` = 0 from N+1 until the cycle after `resolve_branch_i`.

## Test plan
- Fill/drain, DEPTH=4, no ctrl flow:
  - 6 back-to-back pushes with `issue_ack_i`=0 → acks in cycles 0–3 only; `full_o`=1 and `count_o`=4 from cycle 4.
  - Then `issue_ack_i`=1 → entries pop in push order, trans_ids 0,1,2,3.
- Streaming: push every cycle with `issue_ack_i`=1 → `count_o` stays 1 and output order is preserved across 10 pointer wraps.
- Branch gating:
  - Push A (ctrl), B, C; ack every cycle → A issues, then `issue_instr_valid_o`=0 and `branch_pending_o`=1.
  - Hold 3 cycles, pulse `resolve_branch_i` → B valid the next cycle.
  - Coincidence case: resolve in the same cycle as a second ctrl pop → pending stays 1.
- Flush: with 3 entries and PENDING, assert `flush_i` together with a valid push → push not acked; next cycle `count_o`=0, `branch_pending_o`=0, `issue_instr_valid_o`=0. Repeat with `clr_uarch_i`, same result.
- Full plus simultaneous traffic: `count_o`=4, push valid, pop acked → push refused, `count_o`=3 next cycle.
- Asynchronous reset mid-stream: assert `rst_i` between clock edges with 2 entries queued → `issue_instr_valid_o`=0 and `count_o`=0 immediately; the first push after release appears at the head one cycle later.

Source files
------------

// File: rtl/decode_issue_queue.sv
// ---------------------------------------------------------------------------
// decode_issue_queue
//
// Small in-order FIFO sitting between decode and issue. It absorbs
// single-cycle issue back-pressure so decode does not stall, and it holds
// back further issue while a control-flow instruction that has already
// issued is still unresolved in execute.
//
// Ports:
//   clk_i                 clock, rising edge
//   rst_i                 asynchronous active-high reset
//   flush_i               drop all entries and pending-branch state
//   clr_uarch_i           fence.t clear, same effect as flush_i
//   decoded_instr_i       entry from decode
//   decoded_instr_valid_i decode presents an entry
//   is_ctrl_flow_i        presented entry is a branch/jump
//   decoded_instr_ack_o   entry accepted this cycle
//   issue_instr_o         head entry (always shows the head slot)
//   issue_instr_valid_o   head entry may issue
//   is_ctrl_flow_o        head entry is control flow
//   issue_ack_i           issue stage takes the head this cycle
//   resolve_branch_i      execute resolved the outstanding control flow
//   branch_pending_o      an issued control-flow instruction is unresolved
//   count_o               current occupancy
//   full_o                occupancy equals DEPTH
// ---------------------------------------------------------------------------
package decode_issue_queue_pkg;
    typedef struct packed {
        logic [2:0]  trans_id;
        logic [3:0]  fu;
        logic [7:0]  op;
        logic [31:0] pc;
    } scoreboard_entry_t;
endpackage

module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              clr_uarch_i,
    input  scoreboard_entry_t decoded_instr_i,
    input  logic              decoded_instr_valid_i,
    input  logic              is_ctrl_flow_i,
    output logic              decoded_instr_ack_o,
    output scoreboard_entry_t issue_instr_o,
    output logic              issue_instr_valid_o,
    output logic              is_ctrl_flow_o,
    input  logic              issue_ack_i,
    input  logic              resolve_branch_i,
    output logic              branch_pending_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } branch_state_e;

    // Slot 0 lives in its own resettable register so the head reads as zero
    // straight out of reset; the remaining slots need no reset. Element 0 of
    // the plain array is written but never read.
    scoreboard_entry_t r_entry [DEPTH];
    logic              r_ctrlFlow [DEPTH];
    scoreboard_entry_t r_slot0Entry;
    logic              r_slot0CtrlFlow;

    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;
    branch_state_e     r_state;
    branch_state_e     w_stateNext;

    logic              w_clear;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    scoreboard_entry_t w_headEntry;
    logic              w_headCtrlFlow;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_clear = flush_i | clr_uarch_i;
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Push acceptance deliberately ignores issue_ack_i so that no
    // combinational path runs from issue back into decode.
    assign w_push  = decoded_instr_valid_i & ~w_full & ~w_clear & ~rst_i;
    assign w_valid = ~w_empty & (r_state == ST_IDLE);
    assign w_pop   = w_valid & issue_ack_i;

    assign w_headEntry    = (r_rdPtr == '0) ? r_slot0Entry    : r_entry[r_rdPtr];
    assign w_headCtrlFlow = (r_rdPtr == '0) ? r_slot0CtrlFlow : r_ctrlFlow[r_rdPtr];

    // Unreset entry storage, written at the write pointer on every push.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_entry[r_wrPtr]    <= decoded_instr_i;
            r_ctrlFlow[r_wrPtr] <= is_ctrl_flow_i;
        end
    end

    // Resettable copy of slot 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slot0Entry    <= '0;
            r_slot0CtrlFlow <= 1'b0;
        end else if (w_push && (r_wrPtr == '0)) begin
            r_slot0Entry    <= decoded_instr_i;
            r_slot0CtrlFlow <= is_ctrl_flow_i;
        end
    end

    // Pointers and occupancy; a clear wins over any push or pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Branch gating state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Branch gating next state. A resolve in IDLE refers to an older
    // instruction, so a coinciding control-flow pop still enters PENDING.
    always_comb begin
        w_stateNext = r_state;
        if (w_clear) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_pop && w_headCtrlFlow) w_stateNext = ST_PENDING;
                ST_PENDING: if (resolve_branch_i)        w_stateNext = ST_IDLE;
                default:    w_stateNext = ST_IDLE;
            endcase
        end
    end

    // Branch gating outputs.
    always_comb begin
        branch_pending_o = (r_state == ST_PENDING);
    end

    assign decoded_instr_ack_o = w_push;
    assign issue_instr_o       = w_headEntry;
    assign is_ctrl_flow_o      = w_headCtrlFlow;
    assign issue_instr_valid_o = w_valid;
    assign count_o             = r_count;
    assign full_o              = w_full;

endmodule
